// File: rtl/loader_pkg.sv
// Shared types for the Arduino nibble-bus loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ACK_WAIT,
        WRITE
    } state_t;

    localparam int NIBBLES_PER_WORD = 4;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous control bit.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (reset) r_chain <= '0;
        else       r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/arduino_loader.sv
// Assembles 16-bit words from a strobe/ack nibble bus and writes them
// to BRAM port b at an auto-incrementing address.
module arduino_loader
    import loader_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE   = 16'h0000,
    parameter logic [15:0] ADDR_LIMIT  = 16'h00FF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ard_strobe,
    input  logic        ard_clear,
    input  logic [3:0]  ard_nibble,
    output logic        ard_ack,
    output logic        we_b,
    output logic [15:0] addr_b,
    output logic [15:0] data_b,
    output logic        full,
    output logic [15:0] words_loaded
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_shreg;
    logic [2:0]  r_nib_cnt;
    logic        w_strobe;
    logic        w_clr;
    logic        w_last;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_strobe (
        .clk   (clk),
        .reset (reset),
        .i_d   (ard_strobe),
        .o_q   (w_strobe)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_clear (
        .clk   (clk),
        .reset (reset),
        .i_d   (ard_clear),
        .o_q   (w_clr)
    );

    assign w_last = (r_nib_cnt == 3'(NIBBLES_PER_WORD));

    // A clear seen during WRITE must suppress the pulse in that same cycle.
    assign we_b = (r_state == WRITE) && !full && !w_clr;

    always_ff @(posedge clk) begin
        if (reset || w_clr) r_state <= IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_strobe) w_next = CAPTURE;
            CAPTURE:  w_next = ACK_WAIT;
            ACK_WAIT: if (!w_strobe) w_next = w_last ? WRITE : IDLE;
            WRITE:    w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ard_ack      <= 1'b0;
            r_nib_cnt    <= '0;
            r_shreg      <= '0;
            addr_b       <= ADDR_BASE;
            data_b       <= '0;
            full         <= 1'b0;
            words_loaded <= '0;
        end else if (w_clr) begin
            ard_ack      <= 1'b0;
            r_nib_cnt    <= '0;
            r_shreg      <= '0;
            addr_b       <= ADDR_BASE;
            full         <= 1'b0;
            words_loaded <= '0;
        end else begin
            unique case (r_state)
                CAPTURE: begin
                    r_shreg   <= {r_shreg[11:0], ard_nibble};
                    r_nib_cnt <= r_nib_cnt + 3'd1;
                    ard_ack   <= 1'b1;
                end
                ACK_WAIT: begin
                    if (!w_strobe) begin
                        ard_ack <= 1'b0;
                        // Register the word so it is stable across the pulse.
                        if (w_last && !full) data_b <= r_shreg;
                    end
                end
                WRITE: begin
                    r_nib_cnt <= '0;
                    if (!full) begin
                        words_loaded <= words_loaded + 16'd1;
                        if (addr_b == ADDR_LIMIT) full <= 1'b1;
                        else                      addr_b <= addr_b + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
